// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, exception flags and
// format helpers that work for any (EXP_W, MAN_W) pair.
package fp_pkg;

    typedef enum logic [2:0] {
        ClsZero,
        ClsNormal,
        ClsInf,
        ClsNan,
        ClsNegInvalid
    } fp_class_e;

    typedef struct packed {
        logic invalid;
        logic inexact;
    } fp_flags_t;

    // Widest format the constant helpers can describe.
    localparam int unsigned MAX_W = 64;

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
    function automatic logic [MAX_W-1:0] fp_qnan(input int unsigned exp_w,
                                                 input int unsigned man_w);
        logic [MAX_W-1:0] q;
        q = '0;
        for (int unsigned i = 0; i < exp_w; i++) begin
            q[man_w + i] = 1'b1;
        end
        q[man_w - 1] = 1'b1;
        return q;
    endfunction

endpackage

// File: rtl/sqrt_root_stage.sv
// One restoring square-root iteration: bring down the next radicand bit pair,
// try subtracting (4*root + 1), and append the resulting root bit.
module sqrt_root_stage #(
    parameter int unsigned MAN_W = 10
) (
    input  logic [MAN_W+3:0] rem,
    input  logic [MAN_W+1:0] root,
    input  logic [1:0]       digits,
    output logic [MAN_W+3:0] next_rem,
    output logic [MAN_W+1:0] next_root
);

    localparam int unsigned RW = MAN_W + 4;

    logic [RW+1:0] shifted;
    logic [RW+1:0] trial;
    logic [RW+1:0] diff;
    logic          fits;

    // Trial subtraction; the remainder never exceeds RW bits after restoring.
    always_comb begin
        shifted   = {rem, digits};
        trial     = {2'b00, root, 2'b01};
        fits      = (shifted >= trial);
        diff      = fits ? (shifted - trial) : shifted;
        next_rem  = RW'(diff);
        next_root = {root[MAN_W:0], fits};
    end

endmodule

// File: rtl/float_sqrt_pipe.sv
// Fully pipelined IEEE-754 square root for any (EXP_W, MAN_W) format:
// unpack stage, MAN_W+2 restoring root stages, round/pack output register.
// A single global advance signal stalls every stage together.
module float_sqrt_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [EXP_W+MAN_W:0]   n,
    input  logic [TAG_W-1:0]       tag_in,
    input  logic                   data_valid_in,
    output logic                   ready_out,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [TAG_W-1:0]       tag_out,
    output logic [1:0]             flags,
    output logic                   data_valid_out,
    input  logic                   ready_in,
    output logic                   busy
);

    localparam int unsigned W    = fp_width(EXP_W, MAN_W);
    localparam int unsigned QW   = MAN_W + 2;
    localparam int unsigned RW   = MAN_W + 4;
    localparam int unsigned RADW = 2 * QW;

    localparam logic [MAX_W-1:0]       QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]           QNAN      = QNAN_WIDE[W-1:0];
    localparam logic signed [EXP_W+1:0] BIAS     = (EXP_W + 2)'(fp_bias(EXP_W));

    logic advance;

    // Unpack-stage signals
    logic                     sgn;
    logic [EXP_W-1:0]         exp_f;
    logic [MAN_W-1:0]         frac_f;
    fp_class_e                cls;
    logic [W-1:0]             spec_res;
    fp_flags_t                spec_fl;
    logic signed [EXP_W+1:0]  e_unb;
    logic signed [EXP_W+1:0]  e_even;
    logic [EXP_W-1:0]         exp_res;
    logic [RADW-1:0]          rad;

    // Pipeline registers; index 0 is the unpack stage, index k follows root stage k.
    logic [QW:0]              vld_q;
    logic [TAG_W-1:0]         tag_q  [0:QW];
    logic                     byp_q  [0:QW];
    logic [W-1:0]             spec_q [0:QW];
    fp_flags_t                fl_q   [0:QW];
    logic [EXP_W-1:0]         exp_q  [0:QW];
    logic [RW-1:0]            rem_q  [0:QW];
    logic [QW-1:0]            root_q [0:QW];
    logic [RADW-1:0]          rad_q  [0:QW-1];

    logic [RW-1:0]            rem_nx  [0:QW-1];
    logic [QW-1:0]            root_nx [0:QW-1];

    // Round-stage signals
    logic [QW-1:0]            q_fin;
    logic                     guard;
    logic                     sticky;
    logic                     rnd;
    logic [MAN_W:0]           frac_sum;
    logic [W-1:0]             out_res;
    fp_flags_t                out_fl;

    assign advance   = !data_valid_out || ready_in;
    assign ready_out = advance;
    assign busy      = data_valid_out || (|vld_q);

    // Classify the operand, precompute special results, exponent and radicand.
    always_comb begin
        sgn      = n[W-1];
        exp_f    = n[W-2:MAN_W];
        frac_f   = n[MAN_W-1:0];
        spec_res = '0;
        spec_fl  = '0;
        if (&exp_f) begin
            cls = (|frac_f) ? ClsNan : (sgn ? ClsNegInvalid : ClsInf);
        end else if (exp_f == '0) begin
            cls = ClsZero; // subnormals flush to zero
        end else begin
            cls = sgn ? ClsNegInvalid : ClsNormal;
        end
        unique case (cls)
            ClsNan, ClsNegInvalid: begin
                spec_res        = QNAN;
                spec_fl.invalid = 1'b1;
            end
            ClsInf:    spec_res = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ClsZero:   spec_res = {sgn, {(W-1){1'b0}}};
            ClsNormal: spec_res = '0;
        endcase
        e_unb   = $signed({2'b00, exp_f}) - BIAS;
        // Odd exponents fold one factor of two into the significand.
        e_even  = e_unb - $signed({{(EXP_W+1){1'b0}}, e_unb[0]});
        exp_res = EXP_W'((e_even >>> 1) + BIAS);
        rad     = e_unb[0] ? {1'b1, frac_f, {(MAN_W+3){1'b0}}}
                           : {2'b01, frac_f, {(MAN_W+2){1'b0}}};
    end

    // Stage valid bits shift together on advance; cleared by reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q <= {vld_q[QW-1:0], data_valid_in};
        end
    end

    // Stage payloads; contents of invalid stages are don't-care.
    always_ff @(posedge clk_in) begin
        if (advance) begin
            tag_q[0]  <= tag_in;
            byp_q[0]  <= (cls != ClsNormal);
            spec_q[0] <= spec_res;
            fl_q[0]   <= spec_fl;
            exp_q[0]  <= exp_res;
            rem_q[0]  <= '0;
            root_q[0] <= '0;
            rad_q[0]  <= rad;
            for (int k = 1; k <= QW; k++) begin
                tag_q[k]  <= tag_q[k-1];
                byp_q[k]  <= byp_q[k-1];
                spec_q[k] <= spec_q[k-1];
                fl_q[k]   <= fl_q[k-1];
                exp_q[k]  <= exp_q[k-1];
                rem_q[k]  <= rem_nx[k-1];
                root_q[k] <= root_nx[k-1];
            end
            for (int k = 1; k < QW; k++) begin
                rad_q[k] <= rad_q[k-1];
            end
        end
    end

    for (genvar i = 0; i < QW; i++) begin : g_root
        sqrt_root_stage #(
            .MAN_W (MAN_W)
        ) u_stage (
            .rem       (rem_q[i]),
            .root      (root_q[i]),
            .digits    (rad_q[i][RADW-1-2*i -: 2]),
            .next_rem  (rem_nx[i]),
            .next_root (root_nx[i])
        );
    end

    // Round to nearest-even on guard/sticky, or pass the bypassed special result.
    always_comb begin
        q_fin    = root_q[QW];
        guard    = q_fin[0];
        sticky   = |rem_q[QW];
        rnd      = guard & (sticky | q_fin[1]);
        frac_sum = {1'b0, q_fin[QW-2:1]} + (MAN_W + 1)'(rnd);
        out_res  = {1'b0, exp_q[QW], frac_sum[MAN_W-1:0]};
        out_fl   = '0;
        out_fl.inexact = guard | sticky;
        if (byp_q[QW]) begin
            out_res = spec_q[QW];
            out_fl  = fl_q[QW];
        end
    end

    // Registered outputs hold until the downstream accepts them.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            data_valid_out <= 1'b0;
            result         <= '0;
            tag_out        <= '0;
            flags          <= '0;
        end else if (advance) begin
            data_valid_out <= vld_q[QW];
            result         <= out_res;
            tag_out        <= tag_q[QW];
            flags          <= out_fl;
        end
    end

    // The root of a value in [1,4) has its leading one set and cannot round past 2.
    always_ff @(posedge clk_in) begin
        if (rst_n && advance && vld_q[QW] && !byp_q[QW]) begin
            assert (!frac_sum[MAN_W]);
            assert (q_fin[QW-1]);
        end
    end

endmodule

// File: tb/tb_float_sqrt_pipe.sv
// Self-checking bench for float_sqrt_pipe: binary16 and binary32 instances
// checked against a real-valued round-to-nearest-even square-root model.
module tb_float_sqrt_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [15:0] n16, res16;
    logic [3:0]  tin16, tout16;
    logic [1:0]  fl16;
    logic        dvin16, rdy16, dvout16, rin16, busy16;

    logic [31:0] n32, res32;
    logic [3:0]  tin32, tout32;
    logic [1:0]  fl32;
    logic        dvin32, rdy32, dvout32, rin32, busy32;

    int total;
    int bad;

    float_sqrt_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut16 (
        .clk_in(clk), .rst_n(rst_n), .n(n16), .tag_in(tin16), .data_valid_in(dvin16),
        .ready_out(rdy16), .result(res16), .tag_out(tout16), .flags(fl16),
        .data_valid_out(dvout16), .ready_in(rin16), .busy(busy16)
    );

    float_sqrt_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut32 (
        .clk_in(clk), .rst_n(rst_n), .n(n32), .tag_in(tin32), .data_valid_in(dvin32),
        .ready_out(rdy32), .result(res32), .tag_out(tout32), .flags(fl32),
        .data_valid_out(dvout32), .ready_in(rin32), .busy(busy32)
    );

    function automatic real pow2(input int e);
        real p;
        p = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
        else        for (int i = 0; i < -e; i++) p = p / 2.0;
        return p;
    endfunction

    // Returns {invalid, inexact, result[31:0]} for a format (ew, mw).
    function automatic logic [33:0] ref_sqrt(input logic [31:0] x, input int ew, input int mw);
        longint emax, b, e, f, m;
        logic s;
        logic [31:0] qnan, r;
        logic [1:0] fl;
        real xv, y, sc, fr, rr;
        int k;
        emax = (longint'(1) << ew) - 1;
        b    = (longint'(1) << (ew - 1)) - 1;
        e    = (longint'(x) >> mw) & emax;
        f    = longint'(x) & ((longint'(1) << mw) - 1);
        s    = x[ew + mw];
        qnan = 32'((emax << mw) | (longint'(1) << (mw - 1)));
        fl   = 2'b00;
        if (e == emax) begin
            if (f != 0 || s) begin r = qnan; fl = 2'b10; end
            else r = 32'(emax << mw);
        end else if (e == 0) begin
            r = s ? 32'(longint'(1) << (ew + mw)) : 32'h0;
        end else if (s) begin
            r = qnan; fl = 2'b10;
        end else begin
            xv = (1.0 + real'(f) / pow2(mw)) * pow2(int'(e - b));
            y  = $sqrt(xv);
            k  = 0;
            while (y >= 2.0) begin y = y / 2.0; k++; end
            while (y < 1.0) begin y = y * 2.0; k--; end
            sc = y * pow2(mw);
            m  = longint'($rtoi(sc));
            fr = sc - real'(m);
            if (fr > 0.5 || (fr == 0.5 && m[0])) m++;
            if (m == (longint'(1) << (mw + 1))) begin m = m >> 1; k++; end
            rr = real'(m) * pow2(k - mw);
            fl[0] = (rr * rr != xv);
            r = 32'(((longint'(k) + b) << mw) | (m - (longint'(1) << mw)));
        end
        return {fl, r};
    endfunction

    // Issue one operand into an idle binary16 pipe and wait for its result.
    task automatic run16(input logic [15:0] x, input logic [3:0] t, output logic [15:0] r,
                         output logic [1:0] f, output logic [3:0] tg, output int lat);
        @(negedge clk);
        n16 = x; tin16 = t; dvin16 = 1'b1; rin16 = 1'b1;
        @(negedge clk);
        dvin16 = 1'b0;
        lat = 1;
        while (!dvout16 && lat < 60) begin @(negedge clk); lat++; end
        r = res16; f = fl16; tg = tout16;
    endtask

    task automatic run32(input logic [31:0] x, output logic [31:0] r, output logic [1:0] f,
                         output int lat);
        @(negedge clk);
        n32 = x; tin32 = 4'h9; dvin32 = 1'b1; rin32 = 1'b1;
        @(negedge clk);
        dvin32 = 1'b0;
        lat = 1;
        while (!dvout32 && lat < 80) begin @(negedge clk); lat++; end
        r = res32; f = fl32;
    endtask

    task automatic test_reset;
        total++; if (res16 !== 16'h0)  begin bad++; $display("FAIL reset_result: got %h want 0000", res16); end
        total++; if (fl16 !== 2'b00)   begin bad++; $display("FAIL reset_flags: got %b want 00", fl16); end
        total++; if (tout16 !== 4'h0)  begin bad++; $display("FAIL reset_tag: got %h want 0", tout16); end
        total++; if (dvout16 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dvout16); end
        total++; if (busy16 !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy16); end
        total++; if (rdy16 !== 1'b1)   begin bad++; $display("FAIL reset_ready: got %b want 1", rdy16); end
        total++; if (dvout32 !== 1'b0 || busy32 !== 1'b0 || rdy32 !== 1'b1) begin
            bad++; $display("FAIL reset_b32: got valid=%b busy=%b ready=%b want 0 0 1",
                            dvout32, busy32, rdy32);
        end
    endtask

    task automatic test_exact;
        logic [15:0] xs [4] = '{16'h4400, 16'h4880, 16'h3400, 16'h4000};
        logic [15:0] er [4] = '{16'h4000, 16'h4200, 16'h3800, 16'h3DA8};
        logic [1:0]  ef [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
        logic [15:0] r; logic [1:0] f; logic [3:0] tg; int lat;
        for (int i = 0; i < 4; i++) begin
            run16(xs[i], 4'(i + 3), r, f, tg, lat);
            total++; if (r !== er[i]) begin bad++; $display("FAIL exact_result %h: got %h want %h", xs[i], r, er[i]); end
            total++; if (f !== ef[i]) begin bad++; $display("FAIL exact_flags %h: got %b want %b", xs[i], f, ef[i]); end
            total++; if (lat != 14)   begin bad++; $display("FAIL exact_latency %h: got %0d want 14", xs[i], lat); end
            total++; if (tg !== 4'(i + 3)) begin bad++; $display("FAIL exact_tag %h: got %h want %h", xs[i], tg, 4'(i + 3)); end
        end
    endtask

    task automatic test_specials;
        logic [15:0] xs [5] = '{16'hBC00, 16'h7C00, 16'h8000, 16'h0001, 16'h7D00};
        logic [15:0] er [5] = '{16'h7E00, 16'h7C00, 16'h8000, 16'h0000, 16'h7E00};
        logic [1:0]  ef [5] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
        logic [15:0] r; logic [1:0] f; logic [3:0] tg; int lat;
        for (int i = 0; i < 5; i++) begin
            run16(xs[i], 4'hA, r, f, tg, lat);
            total++; if (r !== er[i] || f !== ef[i]) begin
                bad++; $display("FAIL special %h: got %h/%b want %h/%b", xs[i], r, f, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back_sweep;
        logic [37:0] q[$]; logic [37:0] e; logic [33:0] m;
        int sent, rcv, cyc;
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < 31744 && cyc < 40000) begin
            @(negedge clk); cyc++;
            rin16 = 1'b1;
            if (sent < 31744) begin n16 = 16'(sent); tin16 = 4'(sent); dvin16 = 1'b1; end
            else dvin16 = 1'b0;
            #1;
            if (dvout16 && rin16) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL sweep_extra: got %h want nothing", res16);
                end else begin
                    e = q.pop_front();
                    if ({res16, fl16, tout16} !== e[21:0]) begin
                        bad++;
                        $display("FAIL sweep %h: got %h/%b tag %h want %h/%b tag %h",
                                 e[37:22], res16, fl16, tout16, e[21:6], e[5:4], e[3:0]);
                    end
                end
                rcv++;
            end
            if (dvin16 && rdy16) begin
                m = ref_sqrt({16'h0, n16}, 5, 10);
                q.push_back({n16, m[15:0], m[33:32], tin16});
                sent++;
            end
        end
        dvin16 = 1'b0;
        total++; if (rcv != 31744) begin bad++; $display("FAIL sweep_count: got %0d want 31744", rcv); end
    endtask

    task automatic test_backpressure;
        logic [37:0] q[$]; logic [37:0] e; logic [33:0] m; logic [21:0] held_val;
        logic held;
        int sent, rcv, cyc;
        sent = 0; rcv = 0; cyc = 0; held = 1'b0; held_val = '0;
        while (rcv < 40 && cyc < 2000) begin
            @(negedge clk); cyc++;
            rin16  = ($urandom_range(0, 3) != 0);
            n16    = 16'($urandom);
            tin16  = 4'(sent);
            dvin16 = (sent < 40) && ($urandom_range(0, 9) < 6);
            #1;
            if (held) begin
                total++;
                if (!dvout16 || {res16, fl16, tout16} !== held_val) begin
                    bad++; $display("FAIL stall_stable: got v=%b %h want v=1 %h", dvout16,
                                    {res16, fl16, tout16}, held_val);
                end
            end
            held = dvout16 && !rin16;
            held_val = {res16, fl16, tout16};
            if (dvout16 && rin16) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_extra: got %h want nothing", res16);
                end else begin
                    e = q.pop_front();
                    if ({res16, fl16, tout16} !== e[21:0]) begin
                        bad++;
                        $display("FAIL bp_order %h: got %h/%b tag %h want %h/%b tag %h",
                                 e[37:22], res16, fl16, tout16, e[21:6], e[5:4], e[3:0]);
                    end
                end
                rcv++;
            end
            if (dvin16 && rdy16) begin
                m = ref_sqrt({16'h0, n16}, 5, 10);
                q.push_back({n16, m[15:0], m[33:32], tin16});
                sent++;
            end
        end
        dvin16 = 1'b0; rin16 = 1'b1;
        total++; if (rcv != 40 || q.size() != 0) begin
            bad++; $display("FAIL bp_count: got %0d received %0d pending want 40 0", rcv, q.size());
        end
    endtask

    task automatic test_reset_midstream;
        int lat, extra;
        rin16 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n16 = 16'h3C00 + 16'(i * 37); tin16 = 4'(i); dvin16 = 1'b1;
        end
        @(negedge clk); dvin16 = 1'b0;
        repeat (12) @(negedge clk);
        total++; if (dvout16 !== 1'b1 || busy16 !== 1'b1) begin
            bad++; $display("FAIL mid_prefill: got valid=%b busy=%b want 1 1", dvout16, busy16);
        end
        rst_n = 1'b0;
        #1;
        total++; if (dvout16 !== 1'b0 || res16 !== 16'h0 || fl16 !== 2'b00 || tout16 !== 4'h0) begin
            bad++; $display("FAIL mid_reset_out: got v=%b %h/%b tag %h want 0 0000/00 tag 0",
                            dvout16, res16, fl16, tout16);
        end
        total++; if (busy16 !== 1'b0 || rdy16 !== 1'b1) begin
            bad++; $display("FAIL mid_reset_busy: got busy=%b ready=%b want 0 1", busy16, rdy16);
        end
        @(negedge clk);
        rst_n = 1'b1; n16 = 16'h4400; tin16 = 4'h6; dvin16 = 1'b1; rin16 = 1'b1;
        @(negedge clk);
        dvin16 = 1'b0; lat = 1;
        while (!dvout16 && lat < 60) begin @(negedge clk); lat++; end
        total++; if (lat != 14 || res16 !== 16'h4000 || tout16 !== 4'h6) begin
            bad++; $display("FAIL mid_after: got lat=%0d %h tag %h want 14 4000 tag 6",
                            lat, res16, tout16);
        end
        extra = 0;
        repeat (20) begin @(negedge clk); if (dvout16) extra++; end
        total++; if (extra != 0) begin bad++; $display("FAIL mid_stale: got %0d want 0", extra); end
    endtask

    task automatic test_binary32;
        logic [31:0] r, x; logic [1:0] f; logic [33:0] m; int lat;
        run32(32'h40800000, r, f, lat);
        total++; if (r !== 32'h40000000 || f !== 2'b00) begin
            bad++; $display("FAIL b32_four: got %h/%b want 40000000/00", r, f);
        end
        total++; if (lat != 27) begin bad++; $display("FAIL b32_latency: got %0d want 27", lat); end
        run32(32'h40000000, r, f, lat);
        total++; if (r !== 32'h3FB504F3 || f !== 2'b01) begin
            bad++; $display("FAIL b32_two: got %h/%b want 3fb504f3/01", r, f);
        end
        for (int i = 0; i < 8; i++) begin
            x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            m = ref_sqrt(x, 8, 23);
            run32(x, r, f, lat);
            total++; if (r !== m[31:0] || f !== m[33:32]) begin
                bad++; $display("FAIL b32_rand %h: got %h/%b want %h/%b", x, r, f, m[31:0], m[33:32]);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        n16 = '0; tin16 = '0; dvin16 = 1'b0; rin16 = 1'b1;
        n32 = '0; tin32 = '0; dvin32 = 1'b0; rin32 = 1'b1;
        repeat (3) @(negedge clk);
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_exact;
        test_specials;
        test_backpressure;
        test_back_to_back_sweep;
        test_reset_midstream;
        test_binary32;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/float_sqrt_pipe.md
# float_sqrt_pipe

Parametrised, fully pipelined IEEE-754 square root with valid/ready flow control. It handles any (EXP_W, MAN_W) format and accepts one operand per cycle when not stalled. It rounds to nearest-even, implements IEEE special cases and raises invalid/inexact flags. It sits in the simulator datapath alongside the other floating-point units and is the drop-in successor to the fixed binary16 square-root unit.

## Interface
Parameters:
- EXP_W, 5, exponent field width
- MAN_W, 10, stored fraction width; total width W = 1+EXP_W+MAN_W
- TAG_W, 4, opaque sideband carried alongside each operand

Ports:
- clk_in  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- n  in  W  operand
- tag_in  in  TAG_W  sideband, returned unchanged with the result
- data_valid_in  in  1  operand valid
- ready_out  out  1  unit can accept n this cycle
- result  out  W  rounded square root
- tag_out  out  TAG_W  tag of result
- flags  out  2  {invalid, inexact}
- data_valid_out  out  1  result valid
- ready_in  in  1  downstream accepts result
- busy  out  1  any stage holds a valid operand

## Operation
- Input accept: transfer when data_valid_in && ready_out. Output transfer: when data_valid_out && ready_in.
- Classify in unpack stage, bias B = 2^(EXP_W-1)-1:
  - NaN, or negative nonzero (including -inf): result = quiet NaN {0, all-ones exp, 1, zeros}, invalid=1.
  - +inf: result +inf, flags 0.
  - ±0: result is the same signed zero, flags 0.
  - Subnormal: treat as same-signed zero (DAZ), flags 0.
- Normal x = 1.f·2^e:
  - If e is odd: significand m' = 2·1.f and e' = e-1; otherwise m' = 1.f and e' = e.
  - Result biased exponent = e'/2 + B. Arithmetic shift is required because e' can be negative.
- Root: restoring digit-by-digit square root, one root bit per stage, MAN_W+2 stages. This yields the leading 1, MAN_W fraction bits and a guard bit.
  - Remainder is MAN_W+4 bits wide.
  - sticky = (final remainder != 0).
- Round: round to nearest, ties to even, on guard/sticky; inexact = guard|sticky.
  - Significand carry-out is mathematically impossible. A simulation assertion checks this.
- Powers of 4 (fraction 0, even e) must produce fraction 0 exactly, with no off-by-one in the root.
- Special-case operands bypass the root arithmetic; their precomputed result travels down the pipe.

## Timing
- Latency L = MAN_W+4 cycles from input transfer to data_valid_out. Stages: 1 unpack, MAN_W+2 root, 1 round/pack (registered outputs). L = 14 for binary16 and 27 for binary32.
- Throughput is 1 per cycle while unstalled.
- Global stall:
  - advance = !data_valid_out || ready_in
  - ready_out = advance, combinational
  - When advance=0, every stage register holds its value.
- Results leave in input order. data_valid_out and result stay stable until transferred.
- Bubbles (data_valid_in=0) propagate as invalid stages. Their data is don't-care but must not raise data_valid_out.
- Reset (asynchronous, any cycle including mid-stream):
  - All stage valid bits = 0.
  - result, tag_out, flags, data_valid_out = 0; busy = 0; ready_out = 1.
  - In-flight operands are discarded.
  - First accept is possible on the first clock edge after rst_n deasserts.
- busy = OR of all stage valid bits, including the output register.

## Structure
- Shared package fp_pkg holds:
  - the classify enum (ZERO, NORMAL, INF, NAN, NEG_INVALID)
  - a flags struct
  - width functions (W, bias) and the canonical-qNaN constant, all as functions of EXP_W/MAN_W
- One sub-module, sqrt_root_stage: a single restoring iteration (remainder, partial root, next-bit select). It is instantiated MAN_W+2 times by a generate loop. All other logic stays in float_sqrt_pipe.

## Test plan
- Exact roots, binary16, ready_in=1:
  - 0x4400 (4.0) -> 0x4000
  - 0x4880 (9.0) -> 0x4200
  - 0x3400 (0.25) -> 0x3800
  - each with flags 00 and exactly 14 cycles latency.
- Rounding: 0x4000 (2.0) -> 0x3DA8, inexact=1. Sweep all 31744 positive finite binary16 inputs and compare bit-exact against a real-valued RNE model.
- Specials:
  - 0xBC00 -> 0x7E00, invalid=1
  - 0x7C00 -> 0x7C00
  - 0x8000 -> 0x8000
  - 0x0001 -> 0x0000
  - 0x7D00 -> 0x7E00, invalid=1
- Backpressure: stream 40 operands with random data_valid_in and ready_in. Require results in order, tags matching, no loss or duplication, and outputs stable while stalled.
- Reset mid-stream: assert rst_n low with 10 operands in flight. Outputs and busy must go 0 immediately. The next operand 0x4400 returns 0x4000 after 14 cycles with no stale results.
- Binary32 instance (EXP_W=8, MAN_W=23): 0x40800000 -> 0x40000000 with latency 27; 0x40000000 -> 0x3FB504F3 with inexact=1.
